// File: rtl/seeg_cmd_sequencer.sv
// Command sequencer for the sEEG front end: decodes one-shot command bits into
// exclusive record / impedance-check / stimulation sessions with a bounded drain.
module seeg_cmd_sequencer #(
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int ERR_W         = 8
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic [31:0]      cmd_word,
  input  logic             zchk_done,
  input  logic             stim_done,
  input  logic             dp_idle,
  input  logic             err_clr,
  output logic             rec_en,
  output logic             zchk_start,
  output logic             stim_start,
  output logic             stim_infinite,
  output logic             stim_stop,
  output logic [2:0]       state_code,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt,
  output logic             timeout_flag
);

  localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RECORD   = 3'd1,
    S_ZCHECK   = 3'd2,
    S_STIM_FIN = 3'd3,
    S_STIM_INF = 3'd4,
    S_DRAIN    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [8:0]       cmd_q;
  logic             armed_q;
  logic [8:0]       rise_s;
  logic [2:0]       n_start_s;
  logic             any_start_s, reject_s, timeout_s;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             rec_en_q, rec_en_d, zchk_start_q, zchk_start_d;
  logic             stim_start_q, stim_start_d, stim_inf_q, stim_inf_d;
  logic             stim_stop_q, stim_stop_d, busy_q, busy_d, timeout_q, timeout_d;
  logic             unused_s;

  // The first edge after reset only primes cmd_q, so held bits are not executed.
  assign rise_s      = armed_q ? (cmd_word[8:0] & ~cmd_q) : 9'd0;
  assign n_start_s   = 3'(rise_s[0]) + 3'(rise_s[2]) + 3'(rise_s[6]) + 3'(rise_s[7]);
  assign any_start_s = (n_start_s != 3'd0);
  assign unused_s    = ^{cmd_word[31:9], rise_s[5:3]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= S_IDLE;
      cmd_q   <= 9'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_word[8:0];
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    reject_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (n_start_s > 3'd1) reject_s = 1'b1;
        else if (rise_s[0])   state_d = S_RECORD;
        else if (rise_s[2])   state_d = S_ZCHECK;
        else if (rise_s[6])   state_d = S_STIM_FIN;
        else if (rise_s[7])   state_d = S_STIM_INF;
        else                  state_d = S_IDLE;
      end
      S_RECORD: begin
        reject_s = any_start_s;
        if (rise_s[1]) state_d = S_DRAIN;
        else           state_d = S_RECORD;
      end
      S_ZCHECK: begin
        reject_s = any_start_s;
        if (zchk_done) state_d = S_IDLE;
        else           state_d = S_ZCHECK;
      end
      S_STIM_FIN: begin
        reject_s = any_start_s;
        if (stim_done)      state_d = S_IDLE;
        else if (rise_s[8]) state_d = S_DRAIN;
        else                state_d = S_STIM_FIN;
      end
      S_STIM_INF: begin
        reject_s = any_start_s;
        if (rise_s[8]) state_d = S_DRAIN;
        else           state_d = S_STIM_INF;
      end
      S_DRAIN: begin
        reject_s = any_start_s;
        if (dp_idle) begin
          state_d = S_IDLE;
        end else if (drain_cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          timeout_s = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rec_en_d     = (state_d == S_RECORD);
    busy_d       = (state_d != S_IDLE);
    zchk_start_d = (state_q == S_IDLE) && (state_d == S_ZCHECK);
    stim_start_d = (state_q == S_IDLE) &&
                   ((state_d == S_STIM_FIN) || (state_d == S_STIM_INF));
    stim_stop_d  = ((state_q == S_STIM_FIN) || (state_q == S_STIM_INF)) &&
                   (state_d == S_DRAIN);
    // Mode qualifier is chosen at launch and held through DRAIN.
    if (state_q == S_IDLE)      stim_inf_d = (state_d == S_STIM_INF);
    else if (state_d == S_IDLE) stim_inf_d = 1'b0;
    else                        stim_inf_d = stim_inf_q;
    if ((state_q == S_DRAIN) && (state_d == S_DRAIN)) drain_cnt_d = drain_cnt_q + 1'b1;
    else                                              drain_cnt_d = {CNT_W{1'b0}};
    // Clear is applied before the increment so a coincident rejection yields 1.
    if (err_clr && reject_s)           err_cnt_d = {{(ERR_W-1){1'b0}}, 1'b1};
    else if (err_clr)                  err_cnt_d = {ERR_W{1'b0}};
    else if (reject_s && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + 1'b1;
    else                               err_cnt_d = err_cnt_q;
    if (timeout_s)    timeout_d = 1'b1;
    else if (err_clr) timeout_d = 1'b0;
    else              timeout_d = timeout_q;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rec_en_q     <= 1'b0;
      zchk_start_q <= 1'b0;
      stim_start_q <= 1'b0;
      stim_inf_q   <= 1'b0;
      stim_stop_q  <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      drain_cnt_q  <= {CNT_W{1'b0}};
      err_cnt_q    <= {ERR_W{1'b0}};
    end else begin
      rec_en_q     <= rec_en_d;
      zchk_start_q <= zchk_start_d;
      stim_start_q <= stim_start_d;
      stim_inf_q   <= stim_inf_d;
      stim_stop_q  <= stim_stop_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      drain_cnt_q  <= drain_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rec_en        = rec_en_q;
  assign zchk_start    = zchk_start_q;
  assign stim_start    = stim_start_q;
  assign stim_infinite = stim_inf_q;
  assign stim_stop     = stim_stop_q;
  assign state_code    = state_q;
  assign busy          = busy_q;
  assign err_cnt       = err_cnt_q;
  assign timeout_flag  = timeout_q;

endmodule

// File: tb/tb_seeg_cmd_sequencer.sv
// Bench for seeg_cmd_sequencer: directed scenarios plus random traffic,
// checked each cycle against a session-level model of the command rules.
module tb_seeg_cmd_sequencer;

  localparam int DT    = 16;
  localparam int ERR_W = 3;
  localparam int EMAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      cmd_word = 32'd0;
  logic             zchk_done = 1'b0, stim_done = 1'b0, dp_idle = 1'b0, err_clr = 1'b0;
  logic             rec_en, zchk_start, stim_start, stim_infinite, stim_stop, busy, timeout_flag;
  logic [2:0]       state_code;
  logic [ERR_W-1:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;

  // model state: session id as plain integer, one bit per visible output
  int m_st, m_cnt, m_err;
  bit m_to, m_inf, m_zs, m_ss, m_stop, m_armed;
  logic [31:0] m_prev;

  seeg_cmd_sequencer #(.DRAIN_TIMEOUT(DT), .ERR_W(ERR_W)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .cmd_word(cmd_word),
    .zchk_done(zchk_done), .stim_done(stim_done), .dp_idle(dp_idle), .err_clr(err_clr),
    .rec_en(rec_en), .zchk_start(zchk_start), .stim_start(stim_start),
    .stim_infinite(stim_infinite), .stim_stop(stim_stop), .state_code(state_code),
    .busy(busy), .err_cnt(err_cnt), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_err = 0; m_to = 0; m_inf = 0;
    m_zs = 0; m_ss = 0; m_stop = 0; m_armed = 0; m_prev = 32'd0;
  endtask

  task automatic model_step();
    logic [31:0] r;
    int n;
    bit rej, tset;
    r = m_armed ? (cmd_word & ~m_prev) : 32'd0;
    m_prev = cmd_word;
    m_armed = 1;
    n = int'(r[0]) + int'(r[2]) + int'(r[6]) + int'(r[7]);
    m_zs = 0; m_ss = 0; m_stop = 0; rej = 0; tset = 0;
    if (m_st == 0) begin
      if (n > 1) rej = 1;
      else if (r[0]) m_st = 1;
      else if (r[2]) begin m_st = 2; m_zs = 1; end
      else if (r[6]) begin m_st = 3; m_ss = 1; m_inf = 0; end
      else if (r[7]) begin m_st = 4; m_ss = 1; m_inf = 1; end
    end else begin
      rej = (n > 0);
      case (m_st)
        1: if (r[1]) begin m_st = 5; m_cnt = 0; end
        2: if (zchk_done) m_st = 0;
        3: if (stim_done) m_st = 0;
           else if (r[8]) begin m_st = 5; m_cnt = 0; m_stop = 1; end
        4: if (r[8]) begin m_st = 5; m_cnt = 0; m_stop = 1; end
        5: if (dp_idle) m_st = 0;
           else if (m_cnt == DT - 1) begin m_st = 0; tset = 1; end
           else m_cnt++;
        default: m_st = 0;
      endcase
    end
    if (m_st == 0) m_inf = 0;
    if (err_clr) m_err = 0;
    if (rej && m_err < EMAX) m_err++;
    if (err_clr) m_to = 0;
    if (tset) m_to = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  task automatic compare_all();
    chk("state_code", int'(state_code), m_st);
    chk("busy", int'(busy), int'(m_st != 0));
    chk("rec_en", int'(rec_en), int'(m_st == 1));
    chk("zchk_start", int'(zchk_start), int'(m_zs));
    chk("stim_start", int'(stim_start), int'(m_ss));
    chk("stim_infinite", int'(stim_infinite), int'(m_inf));
    chk("stim_stop", int'(stim_stop), int'(m_stop));
    chk("err_cnt", int'(err_cnt), m_err);
    chk("timeout_flag", int'(timeout_flag), int'(m_to));
  endtask

  always @(negedge clk) compare_all();

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    cyc(); cyc();
    chk("reset_state", int'(state_code), 0);
    rst_n = 1'b1;
    cyc();

    // record session with a 10-cycle drain
    cmd_word = 32'h1; cyc();
    chk("rec_on", int'(rec_en), 1); chk("rec_state", int'(state_code), 1);
    cmd_word = 32'h0; cyc(); cyc();
    cmd_word = 32'h2; cyc();
    for (int i = 0; i < 10; i++) begin
      chk("rec_drain", int'(state_code), 5);
      chk("rec_off", int'(rec_en), 0);
      if (i == 9) dp_idle = 1'b1;
      cyc();
    end
    chk("rec_done", int'(state_code), 0); chk("rec_busy", int'(busy), 0);
    cmd_word = 32'h0; cyc();

    // impedance check with a rejected record start
    cmd_word = 32'h4; cyc();
    chk("zs_pulse", int'(zchk_start), 1); chk("zs_state", int'(state_code), 2);
    cmd_word = 32'h0; cyc();
    chk("zs_once", int'(zchk_start), 0);
    cmd_word = 32'h1; cyc();
    chk("zs_rej_err", int'(err_cnt), 1); chk("zs_rec_off", int'(rec_en), 0);
    cmd_word = 32'h0; zchk_done = 1'b1; cyc(); zchk_done = 1'b0;
    chk("zs_done", int'(state_code), 0);

    // infinite stimulation
    dp_idle = 1'b0;
    cmd_word = 32'h80; cyc();
    chk("si_start", int'(stim_start), 1); chk("si_mode", int'(stim_infinite), 1);
    chk("si_state", int'(state_code), 4);
    cmd_word = 32'h0; stim_done = 1'b1; cyc(); stim_done = 1'b0;
    chk("si_ignore_done", int'(state_code), 4);
    cmd_word = 32'h100; cyc();
    chk("si_stop", int'(stim_stop), 1); chk("si_drain", int'(state_code), 5);
    cmd_word = 32'h0; dp_idle = 1'b1; cyc();
    chk("si_idle", int'(state_code), 0); chk("si_mode_off", int'(stim_infinite), 0);

    // simultaneous starts, clear, clear coinciding with rejection
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("clr", int'(err_cnt), 0);
    cmd_word = 32'h41; cyc();
    chk("multi_state", int'(state_code), 0); chk("multi_err", int'(err_cnt), 1);
    chk("multi_nopulse", int'(stim_start), 0);
    cmd_word = 32'h0; cyc();
    cmd_word = 32'h41; err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("clr_then_rej", int'(err_cnt), 1);
    cmd_word = 32'h0; err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("clr2", int'(err_cnt), 0);

    // drain timeout after aborting a finite train
    dp_idle = 1'b0;
    cmd_word = 32'h40; cyc();
    chk("sf_mode", int'(stim_infinite), 0); chk("sf_state", int'(state_code), 3);
    cmd_word = 32'h100; cyc();
    chk("sf_abort", int'(stim_stop), 1);
    cmd_word = 32'h0;
    for (int i = 0; i < DT; i++) begin
      chk("to_drain", int'(state_code), 5);
      cyc();
    end
    chk("to_idle", int'(state_code), 0); chk("to_flag", int'(timeout_flag), 1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("to_clr", int'(timeout_flag), 0);

    // error counter saturation
    for (int i = 0; i < EMAX + 2; i++) begin
      cmd_word = 32'hC0; cyc(); cmd_word = 32'h0; cyc();
    end
    chk("err_sat", int'(err_cnt), EMAX);

    // command held through reset is not executed
    cmd_word = 32'h1; rst_n = 1'b0; cyc(); cyc();
    rst_n = 1'b1; cyc(); cyc();
    chk("held_state", int'(state_code), 0);
    cmd_word = 32'h0; cyc(); cmd_word = 32'h1; cyc();
    chk("held_rearm", int'(state_code), 1);
    cmd_word = 32'h2; dp_idle = 1'b1; cyc(); cyc(); cmd_word = 32'h0; cyc();

    // reset mid-stimulation drops the mode without a stop pulse
    dp_idle = 1'b0; cmd_word = 32'h80; cyc(); cmd_word = 32'h0; cyc();
    rst_n = 1'b0; #1;
    chk("rst_inf", int'(stim_infinite), 0); chk("rst_stop", int'(stim_stop), 0);
    chk("rst_state", int'(state_code), 0);
    cyc(); rst_n = 1'b1; cyc();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] flip;
      flip = 32'd0;
      foreach (flip[b]) if ($urandom_range(0, 9) == 0) flip[b] = 1'b1;
      if ($urandom_range(0, 3) != 0) flip = flip & 32'h1C7;
      cmd_word  = cmd_word ^ flip;
      zchk_done = ($urandom_range(0, 7) == 0);
      stim_done = ($urandom_range(0, 7) == 0);
      dp_idle   = ($urandom_range(0, 4) == 0);
      err_clr   = ($urandom_range(0, 40) == 0);
      rst_n     = ($urandom_range(0, 600) != 0);
      cyc();
    end
    rst_n = 1'b1;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
